// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - access-size encodings, LSU state codes and byte-enable helper
package load_store_unit_pkg;

    // Shared with the decoder's mem_mode field.
    localparam logic [1:0] MEM_WORD = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_BYTE = 2'b10;
    localparam logic [1:0] MEM_ILL  = 2'b11;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

    function automatic logic [3:0] byte_enables(input logic [1:0] mode, input logic [1:0] off);
        logic [3:0] be;
        case (mode)
            MEM_WORD: be = 4'b1111;
            MEM_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            MEM_BYTE: be = 4'b0001 << off;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_store_unit_mem_load_align.sv
// rtl/load_store_unit_mem_load_align.sv - load lane select and sign/zero extension
module load_store_unit_mem_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] bus_rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  mode,
    input  logic        sign,
    output logic [31:0] data
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        half_v = off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        byte_v = bus_rdata[{off, 3'b000} +: 8];
        case (mode)
            MEM_HALF: data = {{16{sign & half_v[15]}}, half_v};
            MEM_BYTE: data = {{24{sign & byte_v[7]}}, byte_v};
            default:  data = bus_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-access req/ack load/store unit with timeout and core stall
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_mode,
    input  logic        mem_sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    lsu_state_t  state;
    logic [7:0]  timeout_count;
    logic [1:0]  mode_q;
    logic [1:0]  off_q;
    logic        sign_q;
    logic        acc;
    logic        bad;
    logic        go;
    logic [31:0] wdata_next;
    logic [31:0] load_data;

    always_comb begin
        acc = mem_read ^ mem_write;
        bad = (mem_read & mem_write) | (mem_mode == MEM_ILL)
            | ((mem_mode == MEM_WORD) & (addr[1:0] != 2'b00))
            | ((mem_mode == MEM_HALF) & addr[0]);
        go = (state == LSU_IDLE) & acc & ~bad;
        misaligned = (state == LSU_IDLE) & (mem_read | mem_write) & bad;
        // Gate with rst so an in-flight access releases the core in the reset cycle itself.
        stall = ~rst & (go | (state == LSU_REQ));
        case (mem_mode)
            MEM_HALF: wdata_next = {2{wdata[15:0]}};
            MEM_BYTE: wdata_next = {4{wdata[7:0]}};
            default:  wdata_next = wdata;
        endcase
    end

    load_store_unit_mem_load_align u_align (
        .bus_rdata (bus_rdata),
        .off       (off_q),
        .mode      (mode_q),
        .sign      (sign_q),
        .data      (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= LSU_IDLE;
            rdata         <= 32'd0;
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= 32'd0;
            bus_be        <= 4'd0;
            bus_wdata     <= 32'd0;
            bus_err       <= 1'b0;
            timeout_count <= 8'd0;
            mode_q        <= MEM_WORD;
            off_q         <= 2'b00;
            sign_q        <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (go) begin
                        bus_addr      <= {addr[31:2], 2'b00};
                        bus_be        <= byte_enables(mem_mode, addr[1:0]);
                        bus_wdata     <= wdata_next;
                        bus_we        <= mem_write;
                        mode_q        <= mem_mode;
                        off_q         <= addr[1:0];
                        sign_q        <= mem_sign_ext;
                        timeout_count <= 8'd0;
                        bus_req       <= 1'b1;
                        state         <= LSU_REQ;
                    end
                end
                LSU_REQ: begin
                    timeout_count <= timeout_count + 8'd1;
                    if (bus_ack) begin
                        if (!bus_we) begin
                            rdata <= load_data;
                        end
                        bus_req <= 1'b0;
                        state   <= LSU_DONE;
                    end else if (timeout_count + 8'd1 == TIMEOUT_CNT) begin
                        rdata   <= 32'd0;
                        bus_err <= 1'b1;
                        bus_req <= 1'b0;
                        state   <= LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    bus_err <= 1'b0;
                    state   <= LSU_IDLE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, mem_sign_ext;
    logic [1:0]  mem_mode;
    logic [31:0] addr, wdata, rdata;
    logic        stall, misaligned, bus_err, bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int n_cmp = 0;
    int n_err = 0;

    int          o_cyc, o_stall, o_req;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [3:0]  o_be;
    logic        o_we, o_err, o_mis, o_done;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_mode     (mem_mode),
        .mem_sign_ext (mem_sign_ext),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .stall        (stall),
        .misaligned   (misaligned),
        .bus_err      (bus_err),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata)
    );

    // Drives one access as the core would and records what the bus and core saw.
    // waits < 0 means the responder never acks; late=1 acks during DONE.
    task automatic run_access(input logic r, input logic w, input logic [1:0] m, input logic s,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] resp,
                              input int waits, input logic late);
        int   idle_cyc;
        logic seen;
        idle_cyc = 0; seen = 1'b0;
        o_cyc = 0; o_stall = 0; o_req = 0; o_mis = 1'b0; o_done = 1'b0; o_err = 1'b0;
        o_addr = '0; o_wdata = '0; o_rdata = '0; o_be = '0; o_we = 1'b0;
        mem_read = r; mem_write = w; mem_mode = m; mem_sign_ext = s; addr = a; wdata = wd;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            o_cyc++;
            if (stall) o_stall++;
            if (misaligned) o_mis = 1'b1;
            if (bus_req) begin
                seen = 1'b1;
                o_req++;
                o_addr = bus_addr; o_be = bus_be; o_wdata = bus_wdata; o_we = bus_we;
                if (waits >= 0 && o_req > waits) begin
                    bus_ack = 1'b1;
                    bus_rdata = resp;
                end
            end else if (seen) begin
                o_done = 1'b1;
                o_rdata = rdata;
                o_err = bus_err;
                if (late) begin
                    bus_ack = 1'b1;
                    bus_rdata = 32'hFFFF_FFFF;
                end
            end else if (!stall) begin
                idle_cyc++;
            end
            @(posedge clk);
            #1;
            bus_ack = 1'b0;
            if (o_done || idle_cyc == 2) break;
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_read = 0; mem_write = 0; mem_mode = 0; mem_sign_ext = 0; addr = 0; wdata = 0;
        bus_ack = 0; bus_rdata = 0;
        #12;
        n_cmp++;
        if ({rdata, bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err, stall, misaligned} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: rdata=%h req=%b we=%b addr=%h be=%b wd=%h err=%b stall=%b mis=%b, required all zero",
                     rdata, bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err, stall, misaligned);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_loads();
        run_access(1, 0, 2'b10, 0, 32'h103, 0, 32'h80FF_1234, 0, 0);
        n_cmp++; if (o_rdata !== 32'h0000_0080 || !o_done) begin n_err++; $display("FAIL lbu_rdata: got %h done=%b, required 00000080", o_rdata, o_done); end
        n_cmp++; if (o_be !== 4'b1000 || o_addr !== 32'h100 || o_we !== 1'b0) begin n_err++; $display("FAIL lbu_bus: be=%b addr=%h we=%b, required 1000 00000100 0", o_be, o_addr, o_we); end
        n_cmp++; if (o_stall !== 2 || o_cyc !== 3 || o_req !== 1) begin n_err++; $display("FAIL lbu_timing: stall=%0d cyc=%0d req=%0d, required 2 3 1", o_stall, o_cyc, o_req); end
        n_cmp++; if (o_err !== 1'b0) begin n_err++; $display("FAIL lbu_err: got %b, required 0", o_err); end

        run_access(1, 0, 2'b10, 1, 32'h103, 0, 32'h80FF_1234, 0, 0);
        n_cmp++; if (o_rdata !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_neg: got %h, required ffffff80", o_rdata); end
        run_access(1, 0, 2'b10, 1, 32'h100, 0, 32'h80FF_1234, 0, 0);
        n_cmp++; if (o_rdata !== 32'h0000_0034 || o_be !== 4'b0001) begin n_err++; $display("FAIL lb_pos: rdata=%h be=%b, required 00000034 0001", o_rdata, o_be); end

        run_access(1, 0, 2'b01, 1, 32'h102, 0, 32'h8001_7FFF, 0, 0);
        n_cmp++; if (o_rdata !== 32'hFFFF_8001 || o_be !== 4'b1100) begin n_err++; $display("FAIL lh: rdata=%h be=%b, required ffff8001 1100", o_rdata, o_be); end
        run_access(1, 0, 2'b01, 0, 32'h102, 0, 32'h8001_7FFF, 0, 0);
        n_cmp++; if (o_rdata !== 32'h0000_8001) begin n_err++; $display("FAIL lhu: got %h, required 00008001", o_rdata); end
        run_access(1, 0, 2'b01, 1, 32'h100, 0, 32'h8001_7FFF, 0, 0);
        n_cmp++; if (o_rdata !== 32'h0000_7FFF || o_be !== 4'b0011) begin n_err++; $display("FAIL lh_low: rdata=%h be=%b, required 00007fff 0011", o_rdata, o_be); end

        run_access(1, 0, 2'b00, 1, 32'h100, 0, 32'h8001_7FFF, 2, 0);
        n_cmp++; if (o_rdata !== 32'h8001_7FFF || o_be !== 4'b1111) begin n_err++; $display("FAIL lw: rdata=%h be=%b, required 80017fff 1111", o_rdata, o_be); end
        n_cmp++; if (o_cyc !== 5 || o_stall !== 4 || o_req !== 3) begin n_err++; $display("FAIL lw_wait: cyc=%0d stall=%0d req=%0d, required 5 4 3", o_cyc, o_stall, o_req); end
    endtask

    task automatic test_stores();
        run_access(0, 1, 2'b10, 0, 32'h201, 32'h1234_56AB, 32'h5555_5555, 0, 0);
        n_cmp++; if (o_we !== 1'b1 || o_addr !== 32'h200 || o_be !== 4'b0010 || o_wdata !== 32'hABAB_ABAB) begin n_err++; $display("FAIL sb: we=%b addr=%h be=%b wd=%h, required 1 00000200 0010 abababab", o_we, o_addr, o_be, o_wdata); end
        n_cmp++; if (o_rdata !== 32'h8001_7FFF) begin n_err++; $display("FAIL sb_rdata_hold: got %h, required 80017fff", o_rdata); end
        run_access(0, 1, 2'b01, 0, 32'h202, 32'h1234_56AB, 0, 0, 0);
        n_cmp++; if (o_be !== 4'b1100 || o_wdata !== 32'h56AB_56AB) begin n_err++; $display("FAIL sh: be=%b wd=%h, required 1100 56ab56ab", o_be, o_wdata); end
        run_access(0, 1, 2'b00, 0, 32'h204, 32'hDEAD_BEEF, 0, 1, 0);
        n_cmp++; if (o_be !== 4'b1111 || o_wdata !== 32'hDEAD_BEEF || o_addr !== 32'h204 || o_cyc !== 4) begin n_err++; $display("FAIL sw: be=%b wd=%h addr=%h cyc=%0d, required 1111 deadbeef 00000204 4", o_be, o_wdata, o_addr, o_cyc); end
    endtask

    task automatic test_misaligned();
        logic [3:0] rd [4]  = '{1, 0, 1, 1};
        logic [3:0] wr [4]  = '{0, 1, 0, 1};
        logic [1:0] md [4]  = '{2'b00, 2'b01, 2'b11, 2'b00};
        logic [31:0] ad [4] = '{32'h101, 32'h203, 32'h100, 32'h100};
        for (int i = 0; i < 4; i++) begin
            run_access(rd[i][0], wr[i][0], md[i], 0, ad[i], 32'h1, 32'h0, 0, 0);
            n_cmp++;
            if (o_mis !== 1'b1 || o_stall !== 0 || o_req !== 0) begin
                n_err++;
                $display("FAIL misaligned_%0d: mis=%b stall=%0d req=%0d, required 1 0 0", i, o_mis, o_stall, o_req);
            end
        end
    endtask

    task automatic test_timeout();
        run_access(1, 0, 2'b00, 0, 32'h400, 0, 32'h0, -1, 1);
        n_cmp++; if (o_req !== 4 || !o_done) begin n_err++; $display("FAIL timeout_req: req=%0d done=%b, required 4 1", o_req, o_done); end
        n_cmp++; if (o_err !== 1'b1 || o_rdata !== 32'h0) begin n_err++; $display("FAIL timeout_done: err=%b rdata=%h, required 1 00000000", o_err, o_rdata); end
        @(negedge clk);
        n_cmp++; if (bus_err !== 1'b0 || rdata !== 32'h0 || bus_req !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL late_ack: err=%b rdata=%h req=%b stall=%b, required 0 00000000 0 0", bus_err, rdata, bus_req, stall); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        mem_read = 1; mem_write = 0; mem_mode = 2'b00; mem_sign_ext = 0; addr = 32'h300;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (bus_req !== 1'b1 || stall !== 1'b1) begin n_err++; $display("FAIL pre_reset_req: req=%b stall=%b, required 1 1", bus_req, stall); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (bus_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0) begin n_err++; $display("FAIL mid_reset: req=%b stall=%b rdata=%h, required 0 0 00000000", bus_req, stall, rdata); end
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_access(1, 0, 2'b00, 0, 32'h300, 0, 32'h1122_3344, 0, 0);
        n_cmp++; if (o_rdata !== 32'h1122_3344 || o_cyc !== 3 || !o_done) begin n_err++; $display("FAIL post_reset_lw: rdata=%h cyc=%0d done=%b, required 11223344 3 1", o_rdata, o_cyc, o_done); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
